// File: rtl/mux_nw_pipe.sv
// N-input channel mux with a one-stage registered output; external select (MODE=0) or round-robin (MODE=1).
// Optional skid register under `MUX_NW_PIPE_SKID_EN` (registered ready, 2-word capacity).
module mux_nw_pipe #(
  parameter int WIDTH  = 24,
  parameter int NUM_IN = 4,
  parameter int MODE   = 0,
  localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic [NUM_IN*WIDTH-1:0] InData,
  input  logic [NUM_IN-1:0]       InValid,
  output logic [NUM_IN-1:0]       InReady,
  input  logic [SEL_W-1:0]        Sel,
  output logic [WIDTH-1:0]        OutData,
  output logic [SEL_W-1:0]        OutChan,
  output logic                    OutValid,
  input  logic                    OutReady
);

  logic [WIDTH-1:0] r_out_dat;
  logic [SEL_W-1:0] r_out_chan;
  logic             r_out_vld;
  logic [SEL_W-1:0] r_last;

  logic             w_gnt_vld;
  logic [SEL_W-1:0] w_gnt_idx;
  logic             w_accept;
  logic             w_load;
  logic [WIDTH-1:0] w_in_dat;
  int               w_c;

  // Round-robin scans downward in distance so the nearest channel after r_last is written last and wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_c       = 0;
    if (MODE == 0) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if ((int'(Sel) == i) && InValid[i]) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = SEL_W'(i);
        end
      end
    end else begin
      for (int k = NUM_IN; k >= 1; k--) begin
        w_c = (int'(r_last) + k) % NUM_IN;
        if (InValid[w_c]) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = SEL_W'(w_c);
        end
      end
    end
  end

`ifdef MUX_NW_PIPE_SKID_EN
  logic [WIDTH-1:0] r_skid_dat;
  logic [SEL_W-1:0] r_skid_chan;
  logic             r_skid_vld;

  assign w_accept = Reset && !r_skid_vld;
`else
  assign w_accept = Reset && (!r_out_vld || OutReady);
`endif

  assign w_load   = w_gnt_vld && w_accept;
  assign w_in_dat = InData[int'(w_gnt_idx)*WIDTH +: WIDTH];

  always_comb begin
    InReady = '0;
    if (w_load) InReady[w_gnt_idx] = 1'b1;
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_out_dat  <= '0;
      r_out_chan <= '0;
      r_out_vld  <= 1'b0;
      r_last     <= SEL_W'(NUM_IN - 1);
`ifdef MUX_NW_PIPE_SKID_EN
      r_skid_dat  <= '0;
      r_skid_chan <= '0;
      r_skid_vld  <= 1'b0;
`endif
    end else begin
      if (MODE == 1 && w_load) r_last <= w_gnt_idx;
`ifdef MUX_NW_PIPE_SKID_EN
      // Skid full blocks loads, so it only ever drains into the main register.
      if (r_skid_vld) begin
        if (OutReady) begin
          r_out_dat  <= r_skid_dat;
          r_out_chan <= r_skid_chan;
          r_out_vld  <= 1'b1;
          r_skid_vld <= 1'b0;
        end
      end else if (w_load) begin
        if (!r_out_vld || OutReady) begin
          r_out_dat  <= w_in_dat;
          r_out_chan <= w_gnt_idx;
          r_out_vld  <= 1'b1;
        end else begin
          r_skid_dat  <= w_in_dat;
          r_skid_chan <= w_gnt_idx;
          r_skid_vld  <= 1'b1;
        end
      end else if (r_out_vld && OutReady) begin
        r_out_vld <= 1'b0;
      end
`else
      if (w_load) begin
        r_out_dat  <= w_in_dat;
        r_out_chan <= w_gnt_idx;
        r_out_vld  <= 1'b1;
      end else if (r_out_vld && OutReady) begin
        r_out_vld <= 1'b0;
      end
`endif
    end
  end

  assign OutData  = r_out_dat;
  assign OutChan  = r_out_chan;
  assign OutValid = r_out_vld;

endmodule

// File: tb/tb_mux_nw_pipe.sv
// Directed bench for mux_nw_pipe (default build): external-select, out-of-range select and round-robin instances.
module tb_mux_nw_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // d0: MODE=0, NUM_IN=4
  logic [4*24-1:0] d0_dat;
  logic [3:0]      d0_vld, d0_rdy;
  logic [1:0]      d0_sel, d0_chan;
  logic [23:0]     d0_odat;
  logic            d0_ovld, d0_ordy;

  // d1: MODE=1, NUM_IN=4
  logic [4*24-1:0] d1_dat;
  logic [3:0]      d1_vld, d1_rdy;
  logic [1:0]      d1_sel, d1_chan;
  logic [23:0]     d1_odat;
  logic            d1_ovld, d1_ordy;

  // d2: MODE=0, NUM_IN=5 (3-bit select, 5..7 out of range)
  logic [5*24-1:0] d2_dat;
  logic [4:0]      d2_vld, d2_rdy;
  logic [2:0]      d2_sel, d2_chan;
  logic [23:0]     d2_odat;
  logic            d2_ovld, d2_ordy;

  mux_nw_pipe #(.WIDTH(24), .NUM_IN(4), .MODE(0)) u_dut0 (
    .Clock(clk), .Reset(rst_n), .InData(d0_dat), .InValid(d0_vld), .InReady(d0_rdy),
    .Sel(d0_sel), .OutData(d0_odat), .OutChan(d0_chan), .OutValid(d0_ovld), .OutReady(d0_ordy));

  mux_nw_pipe #(.WIDTH(24), .NUM_IN(4), .MODE(1)) u_dut1 (
    .Clock(clk), .Reset(rst_n), .InData(d1_dat), .InValid(d1_vld), .InReady(d1_rdy),
    .Sel(d1_sel), .OutData(d1_odat), .OutChan(d1_chan), .OutValid(d1_ovld), .OutReady(d1_ordy));

  mux_nw_pipe #(.WIDTH(24), .NUM_IN(5), .MODE(0)) u_dut2 (
    .Clock(clk), .Reset(rst_n), .InData(d2_dat), .InValid(d2_vld), .InReady(d2_rdy),
    .Sel(d2_sel), .OutData(d2_odat), .OutChan(d2_chan), .OutValid(d2_ovld), .OutReady(d2_ordy));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    d0_dat  = '0; d0_vld = 4'b1111; d0_sel = 2'd0; d0_ordy = 1'b1;
    d1_dat  = '0; d1_vld = 4'b1111; d1_sel = 2'd3; d1_ordy = 1'b1;
    d2_dat  = '0; d2_vld = 5'b0;    d2_sel = 3'd0; d2_ordy = 1'b1;
    for (int c = 0; c < 4; c++) d1_dat[c*24 +: 24] = 24'hC0D000 + 24'(c);
    tick();
    tick();

    // Reset state and ready suppression during reset
    chk("rst_ovld",  32'(d0_ovld), 32'h0);
    chk("rst_odat",  32'(d0_odat), 32'h0);
    chk("rst_ochan", 32'(d0_chan), 32'h0);
    chk("rst_rdy0",  32'(d0_rdy),  32'h0);
    chk("rst_rdy1",  32'(d1_rdy),  32'h0);

    rst_n  = 1'b1;
    d0_vld = 4'b0000;
    d1_vld = 4'b0000;
    tick();

    // Test 1: select ch2
    d0_dat[0*24 +: 24] = 24'h000111;
    d0_dat[1*24 +: 24] = 24'h222333;
    d0_dat[2*24 +: 24] = 24'hABCDEF;
    d0_dat[3*24 +: 24] = 24'h999999;
    d0_sel = 2'd2;
    d0_vld = 4'b0100;
    #1 chk("t1_rdy", 32'(d0_rdy), 32'h4);
    tick();
    chk("t1_odat",  32'(d0_odat), 32'hABCDEF);
    chk("t1_ochan", 32'(d0_chan), 32'h2);
    chk("t1_ovld",  32'(d0_ovld), 32'h1);

    // Test 2: selected channel not valid, others valid
    d0_vld = 4'b1011;
    #1 chk("t2_rdy", 32'(d0_rdy), 32'h0);
    tick();
    chk("t2_ovld",  32'(d0_ovld), 32'h0);
    chk("t2_odat",  32'(d0_odat), 32'hABCDEF);
    chk("t2_ochan", 32'(d0_chan), 32'h2);

    // Test 2b: out-of-range select on 5-input instance, then top channel
    for (int c = 0; c < 5; c++) d2_dat[c*24 +: 24] = 24'h111111 * 24'(c);
    d2_sel = 3'd5;
    d2_vld = 5'b11111;
    #1 chk("t2b_rdy_oor", 32'(d2_rdy), 32'h0);
    tick();
    chk("t2b_ovld_oor", 32'(d2_ovld), 32'h0);
    chk("t2b_odat_oor", 32'(d2_odat), 32'h0);
    d2_sel = 3'd4;
    #1 chk("t2b_rdy4", 32'(d2_rdy), 32'h10);
    tick();
    chk("t2b_odat4",  32'(d2_odat), 32'h444444);
    chk("t2b_ochan4", 32'(d2_chan), 32'h4);
    d2_vld = 5'b0;

    // Test 4: hold under backpressure, then release
    d0_sel  = 2'd0;
    d0_vld  = 4'b0001;
    d0_ordy = 1'b0;
    #1 chk("t4_rdy_load", 32'(d0_rdy), 32'h1);
    tick();
    chk("t4_odat_load", 32'(d0_odat), 32'h000111);
    d0_sel = 2'd1;
    d0_vld = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("t4_rdy_hold%0d", i), 32'(d0_rdy), 32'h0);
      tick();
      chk($sformatf("t4_odat_hold%0d", i), 32'(d0_odat), 32'h000111);
      chk($sformatf("t4_ovld_hold%0d", i), 32'(d0_ovld), 32'h1);
    end
    d0_ordy = 1'b1;
    #1 chk("t4_rdy_rel", 32'(d0_rdy), 32'h2);
    tick();
    chk("t4_odat_rel",  32'(d0_odat), 32'h222333);
    chk("t4_ochan_rel", 32'(d0_chan), 32'h1);
    chk("t4_ovld_rel",  32'(d0_ovld), 32'h1);
    d0_vld = 4'b0000;
    tick();
    chk("t4_ovld_drain", 32'(d0_ovld), 32'h0);

    // Test 3: round-robin rotation with all valid
    d1_vld  = 4'b1111;
    d1_ordy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1 chk($sformatf("t3_rdy%0d", i), 32'(d1_rdy), 32'h1 << (i % 4));
      tick();
      chk($sformatf("t3_ochan%0d", i), 32'(d1_chan), 32'(i % 4));
      chk($sformatf("t3_odat%0d", i),  32'(d1_odat), 32'h00C0D000 + 32'(i % 4));
      chk($sformatf("t3_ovld%0d", i),  32'(d1_ovld), 32'h1);
    end

    // Partial valid: last=1, so ch3 then ch1
    d1_vld = 4'b1010;
    #1 chk("t3_rdy_p0", 32'(d1_rdy), 32'h8);
    tick();
    chk("t3_ochan_p0", 32'(d1_chan), 32'h3);
    #1 chk("t3_rdy_p1", 32'(d1_rdy), 32'h2);
    tick();
    chk("t3_ochan_p1", 32'(d1_chan), 32'h1);

    // No valid channel: no load, pointer unchanged
    d1_vld = 4'b0000;
    #1 chk("t3_rdy_none", 32'(d1_rdy), 32'h0);
    tick();
    chk("t3_ovld_none",  32'(d1_ovld), 32'h0);
    chk("t3_ochan_none", 32'(d1_chan), 32'h1);
    d1_vld  = 4'b1111;
    d1_ordy = 1'b0;
    #1 chk("t3_rdy_after", 32'(d1_rdy), 32'h4);
    tick();
    chk("t3_ochan_after", 32'(d1_chan), 32'h2);
    chk("t3_ovld_after",  32'(d1_ovld), 32'h1);
    #1 chk("t3_rdy_stall", 32'(d1_rdy), 32'h0);

    // Test 5: reset while holding output, first grant afterwards to ch0
    rst_n = 1'b0;
    #1 chk("t5_rdy_rst", 32'(d1_rdy), 32'h0);
    tick();
    chk("t5_ovld",  32'(d1_ovld), 32'h0);
    chk("t5_odat",  32'(d1_odat), 32'h0);
    chk("t5_ochan", 32'(d1_chan), 32'h0);
    rst_n   = 1'b1;
    d1_ordy = 1'b1;
    #1 chk("t5_rdy_first", 32'(d1_rdy), 32'h1);
    tick();
    chk("t5_ochan_first", 32'(d1_chan), 32'h0);
    chk("t5_odat_first",  32'(d1_odat), 32'h00C0D000);
    chk("t5_ovld_first",  32'(d1_ovld), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
